gf180mcu_fd_sc_mcu9t5v0__prbs7_chk: RTL and testbench

Serial PRBS-7 checker (x^7 + x^6 + 1). It is the receive end of the xor2-based PRBS-7 generator used for library characterisation and scan-path BIST. It self-seeds from the incoming bit stream and declares lock after a run of correct predictions. Once locked, it free-runs its own LFSR, flags and counts bit errors, and drops lock when the error density gets too high.

---
 rtl/prbs7_pkg.sv | 28 ++
 rtl/prbs7_lfsr.sv | 41 ++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__prbs7_chk.sv | 167 ++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__prbs7_chk.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/prbs7_pkg.sv
// ============================================================================
//  Module      : prbs7_pkg
//  Description : Shared types and constants for the PRBS-7 (x^7 + x^6 + 1)
//                generator / checker family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prbs7_pkg;

  localparam int PRBS7_W      = 7;
  localparam int PRBS7_TAP_HI = 6;
  localparam int PRBS7_TAP_LO = 5;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs7_state_t;

  // Next sequence bit predicted from the current shift-register contents.
  function automatic logic prbs7_fb(input logic [PRBS7_W-1:0] s);
    return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs7_lfsr.sv
// ============================================================================
//  Module      : prbs7_lfsr
//  Description : 7-bit PRBS-7 shift register. Shifts either an external bit
//                or its own feedback bit; exposes the predicted next bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs7_lfsr
  import prbs7_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               adv_i,
  input  logic               gen_i,
  input  logic               din_i,
  output logic               p_o,
  output logic [PRBS7_W-1:0] nxt_o
);

  logic [PRBS7_W-1:0] s_q;
  logic [PRBS7_W-1:0] s_d;
  logic               shift_bit;

  assign p_o       = prbs7_fb(s_q);
  // Generator mode feeds back the prediction so received errors never enter.
  assign shift_bit = gen_i ? p_o : din_i;
  assign nxt_o     = {s_q[PRBS7_W-2:0], shift_bit};
  assign s_d       = adv_i ? nxt_o : s_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__prbs7_chk.sv
// ============================================================================
//  Module      : gf180mcu_fd_sc_mcu9t5v0__prbs7_chk
//  Description : Self-seeding serial PRBS-7 checker with lock detection,
//                windowed loss-of-lock and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__prbs7_chk
  import prbs7_pkg::*;
#(
  parameter int LOCK_CNT   = 16,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             CLR,
  output logic             LOCK,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(UNLOCK_ERR + 1);

  localparam logic [7:0]        C_MATCH_LAST = 8'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  C_WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0] C_WERR_LAST  = WERR_W'(UNLOCK_ERR - 1);

  prbs7_state_t        state_q, state_d;
  logic [2:0]          seed_cnt_q, seed_cnt_d;
  logic [7:0]          match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]   win_err_q, win_err_d;
  logic                lock_q, lock_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic                gen_mode;
  logic                pred;
  logic [PRBS7_W-1:0]  s_nxt;
  logic                mis;

  assign gen_mode = (state_q == ST_LOCKED);
  assign mis      = D ^ pred;

  prbs7_lfsr u_lfsr (
    .clk_i (CLK),
    .rst_i (RST),
    .adv_i (EN),
    .gen_i (gen_mode),
    .din_i (D),
    .p_o   (pred),
    .nxt_o (s_nxt)
  );

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_d       = 1'b0;

    if (EN) begin
      case (state_q)
        ST_SEED: begin
          if (seed_cnt_q == 3'd6) begin
            seed_cnt_d = 3'd0;
            // An all-zero register is the LFSR lock-up state; keep seeding.
            if (|s_nxt) begin
              state_d     = ST_VERIFY;
              match_cnt_d = 8'd0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end

        ST_VERIFY: begin
          if (mis) begin
            state_d     = ST_SEED;
            seed_cnt_d  = 3'd0;
            match_cnt_d = 8'd0;
          end else if (match_cnt_q == C_MATCH_LAST) begin
            state_d     = ST_LOCKED;
            match_cnt_d = 8'd0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end

        ST_LOCKED: begin
          err_d = mis;
          // The error on the last bit of a window still belongs to it.
          if (mis && (win_err_q == C_WERR_LAST)) begin
            state_d     = ST_SEED;
            seed_cnt_d  = 3'd0;
            match_cnt_d = 8'd0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else if (win_cnt_q == C_WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (mis) begin
              win_err_d = win_err_q + WERR_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_SEED;
        end
      endcase
    end
  end

  assign lock_d = (state_d == ST_LOCKED);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (EN) begin
      if (CLR) begin
        err_cnt_d = ERR_W'(err_d);
      end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_SEED;
      seed_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign LOCK    = lock_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__prbs7_chk.sv
// ============================================================================
//  Module      : tb_gf180mcu_fd_sc_mcu9t5v0__prbs7_chk
//  Description : Directed self-checking bench for the PRBS-7 checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu9t5v0__prbs7_chk;

  logic        CLK = 1'b0;
  logic        RST, EN, D, CLR;
  logic        lock1, err1, lock2, err2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  logic [6:0]  gs;
  logic        b, pb, err_any, lock_any, lock_drop;
  int          passed, total;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__prbs7_chk dut (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .CLR(CLR),
    .LOCK(lock1), .ERR(err1), .ERR_CNT(cnt1)
  );

  gf180mcu_fd_sc_mcu9t5v0__prbs7_chk #(.ERR_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .CLR(CLR),
    .LOCK(lock2), .ERR(err2), .ERR_CNT(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference PRBS-7 generator: new bit = g[6]^g[5], shifted in at the bottom.
  task automatic nxt(output logic nb);
    nb = gs[6] ^ gs[5];
    gs = {gs[5:0], nb};
  endtask

  task automatic cyc(input logic d, input logic en, input logic clr);
    D = d; EN = en; CLR = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      nxt(b);
      cyc(b, 1'b1, 1'b0);
      err_any   |= err1;
      lock_drop |= ~lock1;
    end
  endtask

  initial begin
    passed = 0; total = 0; gs = 7'h7F;
    RST = 1'b1; EN = 1'b0; D = 1'b0; CLR = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("reset_lock", lock1, 0);
    chk("reset_err", err1, 0);
    chk("reset_cnt", cnt1, 0);
    chk("reset_cnt2", cnt2, 0);
    RST = 1'b0;

    // Clean stream: lock after 7 seed + 16 verify bits.
    for (int i = 1; i <= 23; i++) begin
      nxt(b);
      cyc(b, 1'b1, 1'b0);
      if (i == 22) chk("lock_before_23", lock1, 0);
    end
    chk("lock_at_23", lock1, 1);
    err_any = 1'b0; lock_drop = 1'b0;
    clean(254);
    chk("clean_no_err", err_any, 0);
    chk("clean_cnt", cnt1, 0);
    chk("clean_lock_held", lock_drop, 0);

    // Single flipped bit.
    nxt(b);
    cyc(~b, 1'b1, 1'b0);
    chk("flip_err", err1, 1);
    chk("flip_cnt", cnt1, 1);
    chk("flip_lock", lock1, 1);
    nxt(b);
    cyc(b, 1'b1, 1'b0);
    chk("flip_one_pulse", err1, 0);
    err_any = 1'b0; lock_drop = 1'b0;
    clean(50);
    chk("after_flip_no_err", err_any, 0);
    chk("after_flip_lock", lock_drop, 0);

    // CLR alone on a clean bit.
    nxt(b);
    cyc(b, 1'b1, 1'b1);
    chk("clr_alone_cnt", cnt1, 0);
    chk("clr_alone_cnt2", cnt2, 0);

    // Four errors inside one window force loss of lock on the 4th.
    for (int k = 1; k <= 4; k++) begin
      nxt(b);
      cyc(~b, 1'b1, 1'b0);
      chk("burst_err", err1, 1);
      chk("burst_lock", lock1, (k < 4) ? 1 : 0);
      if (k < 4) begin
        nxt(b);
        cyc(b, 1'b1, 1'b0);
      end
    end
    for (int i = 1; i <= 23; i++) begin
      nxt(b);
      cyc(b, 1'b1, 1'b0);
      if (i == 22) chk("relock_before_23", lock1, 0);
    end
    chk("relock_at_23", lock1, 1);
    chk("relock_cnt", cnt1, 4);
    chk("relock_cnt2_sat", cnt2, 3);

    // Reset in the middle of a lock.
    RST = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    RST = 1'b0;
    chk("rst_locked_lock", lock1, 0);
    chk("rst_locked_cnt", cnt1, 0);
    chk("rst_locked_err", err1, 0);

    // All-zero stream never locks.
    lock_any = 1'b0; err_any = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      lock_any |= lock1;
      err_any  |= err1;
    end
    chk("zeros_no_lock", lock_any, 0);
    chk("zeros_no_err", err_any, 0);

    // EN toggling every cycle, junk on D during idle cycles.
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    gs = 7'h7F;
    for (int i = 1; i <= 23; i++) begin
      nxt(b);
      cyc(b, 1'b1, 1'b0);
      if (i == 22) chk("toggle_lock_before", lock1, 0);
      if (i < 23) cyc(i[0], 1'b0, 1'b0);
    end
    chk("toggle_lock_at_23", lock1, 1);

    // A mismatching bit with EN=0 must be ignored.
    pb = gs[6] ^ gs[5];
    cyc(~pb, 1'b0, 1'b0);
    chk("idle_no_err", err1, 0);
    chk("idle_lock", lock1, 1);
    nxt(b);
    cyc(b, 1'b1, 1'b0);
    chk("idle_state_frozen", err1, 0);

    // Errors spaced wider than a window: lock holds, 2-bit counter saturates.
    for (int k = 1; k <= 5; k++) begin
      nxt(b);
      cyc(~b, 1'b1, 1'b0);
      chk("sat_cnt2", cnt2, (k < 3) ? k : 3);
      clean(69);
    end
    chk("sat_lock", lock1, 1);
    chk("sat_cnt16", cnt1, 5);

    nxt(b);
    cyc(~b, 1'b1, 1'b1);
    chk("clr_with_err_cnt2", cnt2, 1);
    chk("clr_with_err_cnt", cnt1, 1);
    nxt(b);
    cyc(b, 1'b1, 1'b1);
    chk("clr_alone2_cnt2", cnt2, 0);
    CLR = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
